// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO drain stage: state encoding and the
// sizing helper for the shared hold/settle down-counter.
package fifo_drain_pkg;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] POP_ASSERT  = 2'd1;
  localparam logic [1:0] POP_RELEASE = 2'd2;
  localparam logic [1:0] PRESENT     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE        = IDLE,
    S_POP_ASSERT  = POP_ASSERT,
    S_POP_RELEASE = POP_RELEASE,
    S_PRESENT     = PRESENT
  } state_e;

  // One counter serves both phases, so it is sized for the longer of the two.
  function automatic int cnt_width(input int pop_hold, input int settle);
    int m;
    m = (pop_hold > settle) ? pop_hold : settle;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fifo_drain.sv
// Drives the byte FIFO's multi-cycle pop handshake and re-presents each popped
// word on a valid/ready stream, hiding pop and flag-settling latency.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int POP_HOLD   = 2,
  parameter int SETTLE     = 2
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  enable,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           byte_count,
  output logic [1:0]            dbg_state
);

  localparam int CW = cnt_width(POP_HOLD, SETTLE);

  if (POP_HOLD < 2 || SETTLE < 2) begin : g_param_check
    $error("fifo_drain: POP_HOLD and SETTLE must both be at least 2");
  end

  // Handshake: out_data/out_valid are held until the edge where
  // out_valid & out_ready are both high; that edge transfers the word.

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pop_q, pop_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           count_q, count_d;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pop_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pop_q   <= pop_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_d   = pop_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        // enable and fifo_empty are only looked at here; a started pop always finishes.
        if (enable && !fifo_empty) begin
          state_d = S_POP_ASSERT;
          pop_d   = 1'b1;
          cnt_d   = CW'(POP_HOLD - 1);
        end
      end
      S_POP_ASSERT: begin
        if (cnt_q == '0) begin
          pop_d   = 1'b0;
          cnt_d   = CW'(SETTLE - 1);
          state_d = S_POP_RELEASE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_POP_RELEASE: begin
        if (cnt_q == '0) begin
          data_d  = fifo_data;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PRESENT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          count_d = count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fifo_pop   = pop_q;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign byte_count = count_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: behavioural FIFO, cycle-timing monitor and in-order
// scoreboard, driven by directed and randomized scenarios.
module tb_fifo_drain;

  localparam int W        = 8;
  localparam int POP_HOLD = 2;
  localparam int SETTLE   = 2;

  logic         clk;
  logic         clear_n;
  logic         enable;
  logic         fifo_pop;
  logic [W-1:0] fifo_data;
  logic         fifo_empty;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [15:0]  byte_count;
  logic [1:0]   dbg_state;

  fifo_drain #(.DATA_WIDTH(W), .POP_HOLD(POP_HOLD), .SETTLE(SETTLE)) dut (
    .clk(clk), .clear_n(clear_n), .enable(enable), .fifo_pop(fifo_pop),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .byte_count(byte_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [15:0]  exp_count = '0;
  int           pop_cnt = 0;
  int           rise_cyc = 0;
  logic         prev_pop = 1'b0;
  logic         prev_valid = 1'b0;
  logic         in_txn = 1'b0;
  logic [W-1:0] held_data = '0;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic         rand_drive = 1'b0;

  // Behavioural FIFO plus monitor. Runs 1 time unit after each falling edge,
  // after drivers have updated their inputs for the coming rising edge.
  always @(negedge clk) begin
    #1;
    if (!clear_n) begin
      prev_pop   = 1'b0;
      prev_valid = 1'b0;
      in_txn     = 1'b0;
      exp_count  = '0;
    end else begin
      if (fifo_pop && !prev_pop) begin
        n_cmp++;
        if (fifo_q.size() == 0) begin
          n_bad++;
          $display("FAIL pop_on_empty: fifo_pop rose at cycle %0d, FIFO holds 0 words, required no pop", cyc);
        end else begin
          fifo_data = fifo_q.pop_front();
        end
        pop_cnt++;
        rise_cyc = cyc;
        in_txn   = 1'b1;
      end
      if (!fifo_pop && prev_pop) begin
        n_cmp++;
        if (cyc - rise_cyc != POP_HOLD) begin
          n_bad++;
          $display("FAIL pop_width: fifo_pop high %0d cycles, required %0d", cyc - rise_cyc, POP_HOLD);
        end
      end
      if (out_valid && !prev_valid) begin
        held_data = out_data;
        n_cmp++;
        if (cyc - rise_cyc != POP_HOLD + SETTLE) begin
          n_bad++;
          $display("FAIL valid_latency: out_valid rose %0d cycles after pop, required %0d",
                   cyc - rise_cyc, POP_HOLD + SETTLE);
        end
      end else if (out_valid && prev_valid) begin
        n_cmp++;
        if (out_data !== held_data) begin
          n_bad++;
          $display("FAIL data_hold: out_data=%02h while held, required %02h", out_data, held_data);
        end
      end
      n_cmp++;
      if (busy !== in_txn) begin
        n_bad++;
        $display("FAIL busy: got %b at cycle %0d, required %b", busy, cyc, in_txn);
      end
      n_cmp++;
      if (byte_count !== exp_count) begin
        n_bad++;
        $display("FAIL byte_count: got %0d, required %0d", byte_count, exp_count);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard: word %02h accepted, none expected", out_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_bad++;
            $display("FAIL scoreboard: got %02h, required %02h", out_data, e);
          end
        end
        acc_q.push_back(cyc + 1);
        exp_count = exp_count + 16'd1;
        in_txn    = 1'b0;
      end
      prev_pop   = fifo_pop;
      prev_valid = out_valid;
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic wait_drained(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rand_drive) begin
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 4) != 0);
      end
      if (exp_q.size() == 0 && !busy && !out_valid) break;
    end
    n_cmp++;
    if (i >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: %0d words undelivered after %0d cycles, required 0", name, exp_q.size(), budget);
    end
  endtask

  task automatic wait_pop(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_pop) break;
    end
    n_cmp++;
    if (i >= budget) begin
      n_bad++;
      $display("FAIL %s_pop_timeout: no fifo_pop within %0d cycles", name, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    fifo_data = '0; fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (fifo_pop !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        byte_count !== 16'd0 || out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state: pop=%b valid=%b busy=%b count=%0d data=%02h, required all 0",
               fifo_pop, out_valid, busy, byte_count, out_data);
    end
    clear_n = 1'b1;
  endtask

  task automatic test_idle_empty();
    enable = 1'b1; out_ready = 1'b1;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (pop_cnt !== 0 || out_valid !== 1'b0 || busy !== 1'b0 || byte_count !== 16'd0) begin
      n_bad++;
      $display("FAIL idle_empty: pops=%0d valid=%b busy=%b count=%0d, required 0/0/0/0",
               pop_cnt, out_valid, busy, byte_count);
    end
  endtask

  task automatic test_single();
    int p0;
    p0 = pop_cnt;
    @(negedge clk);
    push_word(8'hA5);
    wait_drained(100, "single");
    repeat (20) @(negedge clk);
    n_cmp++;
    if (pop_cnt - p0 != 1 || byte_count !== 16'd1 || fifo_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL single: pops=%0d count=%0d empty=%b, required 1/1/1", pop_cnt - p0, byte_count, fifo_empty);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pop_cnt;
    acc_q.delete();
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    wait_drained(200, "b2b");
    n_cmp++;
    if (pop_cnt - p0 != 8 || acc_q.size() != 8) begin
      n_bad++;
      $display("FAIL b2b_count: pops=%0d accepts=%0d, required 8/8", pop_cnt - p0, acc_q.size());
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      n_cmp++;
      if (acc_q[i] - acc_q[i-1] != POP_HOLD + SETTLE + 2) begin
        n_bad++;
        $display("FAIL b2b_spacing: word %0d gap %0d cycles, required %0d",
                 i, acc_q[i] - acc_q[i-1], POP_HOLD + SETTLE + 2);
      end
    end
  endtask

  task automatic test_ready_hold();
    int p0;
    int i;
    p0 = pop_cnt;
    @(negedge clk);
    out_ready = 1'b0;
    push_word(8'h01); push_word(8'h02); push_word(8'h03);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    n_cmp++;
    if (i >= 50) begin
      n_bad++;
      $display("FAIL hold_valid_timeout: out_valid not seen within 50 cycles");
    end
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 || pop_cnt - p0 != 1) begin
        n_bad++;
        $display("FAIL hold: valid=%b data=%02h pops=%0d, required 1/01/1", out_valid, out_data, pop_cnt - p0);
      end
    end
    out_ready = 1'b1;
    wait_drained(100, "hold");
    n_cmp++;
    if (pop_cnt - p0 != 3) begin
      n_bad++;
      $display("FAIL hold_pops: got %0d, required 3", pop_cnt - p0);
    end
  endtask

  task automatic test_enable_drop();
    int p0;
    p0 = pop_cnt;
    @(negedge clk);
    push_word($urandom_range(0, 255)); push_word($urandom_range(0, 255)); push_word($urandom_range(0, 255));
    wait_pop(50, "endrop");
    enable = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (pop_cnt - p0 != 1 || exp_q.size() != 2 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL enable_drop: pops=%0d pending=%0d busy=%b, required 1/2/0", pop_cnt - p0, exp_q.size(), busy);
    end
    enable = 1'b1;
    wait_drained(100, "endrop");
    n_cmp++;
    if (pop_cnt - p0 != 3) begin
      n_bad++;
      $display("FAIL enable_resume: pops=%0d, required 3", pop_cnt - p0);
    end
  endtask

  task automatic test_random();
    rand_drive = 1'b1;
    for (int r = 0; r < 4; r++) begin
      int n;
      @(negedge clk);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) push_word(W'($urandom_range(0, 255)));
      wait_drained(2000, "random");
    end
    rand_drive = 1'b0;
    enable = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_pop();
    @(negedge clk);
    push_word(8'h5A); push_word(8'hC3);
    wait_pop(50, "rstpop");
    @(posedge clk);
    #3 clear_n = 1'b0;
    #1;
    n_cmp++;
    if (fifo_pop !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || byte_count !== 16'd0) begin
      n_bad++;
      $display("FAIL async_reset: pop=%b valid=%b busy=%b count=%0d, required all 0",
               fifo_pop, out_valid, busy, byte_count);
    end
    fifo_q.delete(); exp_q.delete();
    fifo_data = '0; fifo_empty = 1'b1;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    @(negedge clk);
    push_word(8'h3C); push_word(8'h96);
    wait_drained(100, "post_reset");
    n_cmp++;
    if (byte_count !== 16'd2) begin
      n_bad++;
      $display("FAIL post_reset_count: got %0d, required 2", byte_count);
    end
  endtask

  initial begin
    test_reset();
    test_idle_empty();
    test_single();
    test_back_to_back();
    test_ready_hold();
    test_enable_drop();
    test_random();
    test_reset_mid_pop();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Downstream companion stage for the byte FIFO in the serial command path: drives the FIFO's level-sensitive pop protocol, captures each popped word, and presents it on a valid/ready stream to the UART transmitter or command parser. It hides the FIFO's multi-cycle pop handshake and flag-settling latency from the consumer. It never pops while the FIFO reports empty.

## Interface
- DATA_WIDTH, 8: word width, equal to the FIFO's data width
- POP_HOLD, 2: cycles fifo_pop is held high per pop; legal minimum 2
- SETTLE, 2: cycles after pop release before capture and before re-examining fifo_empty; legal minimum 2
- clk  in  1  single clock, rising edge
- clear_n  in  1  reset, asynchronous assert, active-low
- enable  in  1  level; permits new pops
- fifo_pop  out  1  pop request to the FIFO, registered
- fifo_data  in  DATA_WIDTH  FIFO output word
- fifo_empty  in  1  FIFO "popped last" flag; 1 means nothing to pop
- out_data  out  DATA_WIDTH  captured word, stable while out_valid=1
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts on the edge where out_valid & out_ready
- busy  out  1  high in every state except IDLE
- byte_count  out  16  words accepted by the consumer since reset; wraps at 16'hFFFF→0

## Operation
- States: IDLE, POP_ASSERT, POP_RELEASE, PRESENT.
- IDLE:
  - If enable=1 and fifo_empty=0, go to POP_ASSERT, set fifo_pop<=1 and load the counter with POP_HOLD-1.
  - Otherwise stay in IDLE.
- POP_ASSERT:
  - Counter decrements each cycle.
  - At 0, set fifo_pop<=0, load the counter with SETTLE-1, go to POP_RELEASE.
- POP_RELEASE:
  - Counter decrements each cycle.
  - At 0, out_data<=fifo_data, out_valid<=1, go to PRESENT.
- PRESENT:
  - Hold out_data and out_valid until out_valid & out_ready.
  - On that edge: out_valid<=0, byte_count<=byte_count+1, go to IDLE.
- Once a pop starts it always completes, even if enable falls. enable is sampled only in IDLE.
- fifo_empty is sampled only in IDLE. The SETTLE window guarantees the FIFO flag has refreshed after the previous pop.
- out_ready is ignored outside PRESENT.
- Reset (clear_n=0, asynchronous):
  - State=IDLE, counter=0.
  - fifo_pop=0, out_valid=0, out_data=0, byte_count=0, busy=0.
  - If reset lands mid-pop, fifo_pop drops immediately. The FIFO is assumed reset in the same domain event.
- Out-of-range parameters (POP_HOLD<2 or SETTLE<2) are a synthesis-time error.

## Timing
- Let E0 be the edge where IDLE sees enable & !fifo_empty.
- fifo_pop is high from E0 through edge E0+POP_HOLD, low after that edge.
- Capture and out_valid rise on edge E0+POP_HOLD+SETTLE: E0+4 with defaults.
- If out_ready is already high, acceptance happens on the next edge, E0+5.
- Back-to-back throughput with out_ready=1 is one word per POP_HOLD+SETTLE+2 cycles: 6 with defaults.
- busy rises on edge E0 and falls on the acceptance edge. It is combinational from state.
- Empty boundary: if fifo_empty rises after a pop, the following IDLE cycle issues no pop. The block idles indefinitely with no spurious fifo_pop.
- Simultaneous events:
  - enable rising while fifo_empty=1 causes no action.
  - out_ready falling while out_valid=1 means hold. The word is never lost or repeated.

## Structure
- Shared package fifo_drain_pkg holds:
  - state encoding localparams (IDLE=0, POP_ASSERT=1, POP_RELEASE=2, PRESENT=3, 2-bit)
  - the counter width function clog2(max(POP_HOLD,SETTLE)).
- No sub-module. The single hold/settle down-counter and the FSM stay in one file.

## Test plan
- Reset then idle with FIFO empty, enable=1 for 50 cycles -> fifo_pop never asserts; out_valid=0; busy=0; byte_count=0.
- Push 8'hA5 into the FIFO, then enable=1, out_ready=1 -> fifo_pop high for exactly 2 cycles; out_data=8'hA5 with out_valid on E0+4; byte_count=1; fifo_empty=1 afterwards, no further pops.
- Push 8'h01..8'h08 (FIFO full), out_ready=1 -> eight words out in order 01..08, spaced 6 cycles apart; byte_count=8; exactly 8 pop pulses.
- Push 3 words, out_ready=0 for 20 cycles after the first out_valid, then 1 -> out_data holds 8'h01 stable throughout; no second pop until acceptance; all 3 words delivered in order.
- Drop enable one cycle after E0 -> current pop completes and its word is delivered; no further pop until enable returns.
- Assert clear_n=0 during POP_ASSERT -> fifo_pop, out_valid, busy and byte_count go to 0 asynchronously before the next edge; after release, normal operation resumes from IDLE.
